// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage condition logic: ARM condition codes
// and bit positions inside the NZCV flag word and the flag-write-enable field.
package ex_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FWE_NZ = 2;
    localparam int FWE_C  = 1;
    localparam int FWE_V  = 0;

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Pure combinational ARM condition evaluator; also intended for the branch unit.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    import ex_pkg::*;

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // NV is deliberately treated as always-pass rather than never-execute.
    always_comb begin
        pass = 1'b1;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_cond_stage.sv
// Condition stage between execute and memory: owns the NZCV register, gates
// writes by the condition field and registers one instruction toward memory.
module ex_cond_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cond,
    input  logic [DW-1:0] in_result,
    input  logic [3:0]    in_flags,
    input  logic [2:0]    in_flag_we,
    input  logic          in_reg_we,
    input  logic          in_mem_we,
    input  logic [RW-1:0] in_wa,
    input  logic [DW-1:0] in_wdata,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_wa,
    output logic          out_reg_we,
    output logic          out_mem_we,
    output logic          out_pass,
    output logic [3:0]    flags_q,
    output logic          prev_c
);
    import ex_pkg::*;

    logic pass;
    logic accept;

    // Conditions see only flags committed by older instructions, never in_flags.
    cond_check u_cond_check (
        .cond  (in_cond),
        .flags (flags_q),
        .pass  (pass)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign prev_c   = flags_q[FLAG_C];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (accept && pass) begin
            if (in_flag_we[FWE_NZ]) begin
                flags_q[FLAG_N] <= in_flags[FLAG_N];
                flags_q[FLAG_Z] <= in_flags[FLAG_Z];
            end
            if (in_flag_we[FWE_C]) begin
                flags_q[FLAG_C] <= in_flags[FLAG_C];
            end
            if (in_flag_we[FWE_V]) begin
                flags_q[FLAG_V] <= in_flags[FLAG_V];
            end
        end
    end

    // Flush wins over accept and drain; failed conditions still travel as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_reg_we <= 1'b0;
            out_mem_we <= 1'b0;
            out_pass   <= 1'b0;
            out_result <= '0;
            out_wdata  <= '0;
            out_wa     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_reg_we <= 1'b0;
            out_mem_we <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_reg_we <= in_reg_we & pass;
            out_mem_we <= in_mem_we & pass;
            out_pass   <= pass;
            out_result <= in_result;
            out_wdata  <= in_wdata;
            out_wa     <= in_wa;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_cond_stage.sv
// Bench for ex_cond_stage: directed vector table, hand sequences for
// backpressure and async reset, then random traffic against a reference model.
module tb_ex_cond_stage;

    localparam int DW = 32;
    localparam int RW = 4;

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_GT = 4'hC;
    localparam logic [3:0] C_AL = 4'hE;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_cond;
    logic [DW-1:0] in_result;
    logic [3:0]    in_flags;
    logic [2:0]    in_flag_we;
    logic          in_reg_we;
    logic          in_mem_we;
    logic [RW-1:0] in_wa;
    logic [DW-1:0] in_wdata;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_wdata;
    logic [RW-1:0] out_wa;
    logic          out_reg_we;
    logic          out_mem_we;
    logic          out_pass;
    logic [3:0]    flags_q;
    logic          prev_c;

    ex_cond_stage #(.DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cond    (in_cond),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_flag_we (in_flag_we),
        .in_reg_we  (in_reg_we),
        .in_mem_we  (in_mem_we),
        .in_wa      (in_wa),
        .in_wdata   (in_wdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_wdata  (out_wdata),
        .out_wa     (out_wa),
        .out_reg_we (out_reg_we),
        .out_mem_we (out_mem_we),
        .out_pass   (out_pass),
        .flags_q    (flags_q),
        .prev_c     (prev_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          ready;
        logic          fl;
        logic [3:0]    cond;
        logic [3:0]    flags;
        logic [2:0]    fwe;
        logic          reg_we;
        logic          mem_we;
        logic [RW-1:0] wa;
        logic [DW-1:0] result;
        logic [DW-1:0] wdata;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       e_valid;
        logic       e_reg_we;
        logic       e_mem_we;
        logic       e_pass;
        logic [3:0] e_flags;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic          m_valid;
    logic          m_reg_we;
    logic          m_mem_we;
    logic          m_pass;
    logic [3:0]    m_flags;
    logic [DW-1:0] m_result;
    logic [DW-1:0] m_wdata;
    logic [RW-1:0] m_wa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition pairs share a base test; odd codes invert it, 1111 always passes.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c[3:1] == 3'd7) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic modelReset();
        m_valid = 0; m_reg_we = 0; m_mem_we = 0; m_pass = 0;
        m_flags = 4'b0000; m_result = '0; m_wdata = '0; m_wa = '0;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, m_valid});
        chk({tag, ".out_reg_we"}, {31'd0, out_reg_we}, {31'd0, m_reg_we});
        chk({tag, ".out_mem_we"}, {31'd0, out_mem_we}, {31'd0, m_mem_we});
        chk({tag, ".out_pass"},   {31'd0, out_pass},   {31'd0, m_pass});
        chk({tag, ".flags_q"},    {28'd0, flags_q},    {28'd0, m_flags});
        chk({tag, ".prev_c"},     {31'd0, prev_c},     {31'd0, m_flags[1]});
        chk({tag, ".out_result"}, out_result, m_result);
        chk({tag, ".out_wdata"},  out_wdata,  m_wdata);
        chk({tag, ".out_wa"},     {28'd0, out_wa}, {28'd0, m_wa});
    endtask

    // Drive one cycle of inputs, predict the edge, then sample 1 ns after it.
    task automatic applyStimulus(input stim_t s, input string tag);
        logic rdy, acc, p;
        in_valid = s.valid; out_ready = s.ready; flush = s.fl;
        in_cond = s.cond; in_flags = s.flags; in_flag_we = s.fwe;
        in_reg_we = s.reg_we; in_mem_we = s.mem_we; in_wa = s.wa;
        in_result = s.result; in_wdata = s.wdata;
        #1;
        rdy = !m_valid || s.ready;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        acc = s.valid && rdy && !s.fl;
        p = ref_pass(s.cond, m_flags);
        @(posedge clk);
        if (s.fl) begin
            m_valid = 0; m_reg_we = 0; m_mem_we = 0;
        end else if (acc) begin
            if (p) begin
                if (s.fwe[2]) m_flags[3:2] = s.flags[3:2];
                if (s.fwe[1]) m_flags[1]   = s.flags[1];
                if (s.fwe[0]) m_flags[0]   = s.flags[0];
            end
            m_valid = 1; m_reg_we = s.reg_we && p; m_mem_we = s.mem_we && p;
            m_pass = p; m_result = s.result; m_wdata = s.wdata; m_wa = s.wa;
        end else if (m_valid && s.ready) begin
            m_valid = 0;
        end
        #1;
        checkOutput(tag);
    endtask

    function automatic stim_t mk(input logic v, input logic r, input logic f,
                                 input logic [3:0] c, input logic [3:0] fl,
                                 input logic [2:0] we, input logic rw, input logic mw,
                                 input logic [DW-1:0] res);
        stim_t s;
        s.valid = v; s.ready = r; s.fl = f; s.cond = c; s.flags = fl; s.fwe = we;
        s.reg_we = rw; s.mem_we = mw; s.wa = res[3:0]; s.result = res; s.wdata = ~res;
        return s;
    endfunction

    vec_t tbl[9];
    stim_t s;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; flush = 0; in_cond = 0; in_flags = 0;
        in_flag_we = 0; in_reg_we = 0; in_mem_we = 0; in_wa = 0;
        in_result = 0; in_wdata = 0;
        modelReset();
        #12;
        checkOutput("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl[0] = '{mk(1,1,0,C_AL,4'b0110,3'b111,0,0,32'h11), 1,0,0,1,4'b0110};
        tbl[1] = '{mk(1,1,0,C_EQ,4'b0000,3'b000,1,0,32'h22), 1,1,0,1,4'b0110};
        tbl[2] = '{mk(1,1,0,C_NE,4'b0000,3'b000,1,0,32'h33), 1,0,0,0,4'b0110};
        tbl[3] = '{mk(1,1,0,C_AL,4'b1011,3'b111,0,0,32'h44), 1,0,0,1,4'b1011};
        tbl[4] = '{mk(1,1,0,C_AL,4'b0100,3'b100,0,0,32'h55), 1,0,0,1,4'b0111};
        tbl[5] = '{mk(1,1,0,C_AL,4'b1000,3'b111,0,0,32'h66), 1,0,0,1,4'b1000};
        tbl[6] = '{mk(1,1,0,C_GT,4'b0000,3'b111,0,1,32'h77), 1,0,0,0,4'b1000};
        tbl[7] = '{mk(1,1,1,C_AL,4'b1111,3'b111,1,1,32'h88), 0,0,0,0,4'b1000};
        tbl[8] = '{mk(0,1,0,C_AL,4'b0000,3'b000,0,0,32'h99), 0,0,0,0,4'b1000};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_valid", i),  {31'd0, out_valid},  {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d.tbl_reg_we", i), {31'd0, out_reg_we}, {31'd0, tbl[i].e_reg_we});
            chk($sformatf("vec%0d.tbl_mem_we", i), {31'd0, out_mem_we}, {31'd0, tbl[i].e_mem_we});
            chk($sformatf("vec%0d.tbl_pass", i),   {31'd0, out_pass},   {31'd0, tbl[i].e_pass});
            chk($sformatf("vec%0d.tbl_flags", i),  {28'd0, flags_q},    {28'd0, tbl[i].e_flags});
        end

        // Backpressure: held entry must not move while in_ready is low.
        applyStimulus(mk(1,1,0,C_AL,4'b0000,3'b000,1,0,32'hDEADBEEF), "bp_load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1,0,0,C_AL,4'b0000,3'b000,1,0,32'h0BAD0000 + i), "bp_hold");
            chk("bp_hold.in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_hold.result", out_result, 32'hDEADBEEF);
        end
        applyStimulus(mk(1,1,0,C_AL,4'b0000,3'b000,1,0,32'h12345678), "bp_release");
        chk("bp_release.result", out_result, 32'h12345678);
        chk("bp_release.valid", {31'd0, out_valid}, 32'd1);

        // Async reset between edges must clear state without a clock.
        applyStimulus(mk(1,1,0,C_AL,4'b1111,3'b111,1,1,32'hCAFE), "ar_load");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst.flags_q", {28'd0, flags_q}, 32'd0);
        rst_n = 1'b1;
        modelReset();

        for (int i = 0; i < 400; i++) begin
            s.valid  = ($urandom_range(0, 3) != 0);
            s.ready  = ($urandom_range(0, 3) != 0);
            s.fl     = ($urandom_range(0, 15) == 0);
            s.cond   = 4'($urandom_range(0, 15));
            s.flags  = 4'($urandom_range(0, 15));
            s.fwe    = 3'($urandom_range(0, 7));
            s.reg_we = 1'($urandom_range(0, 1));
            s.mem_we = 1'($urandom_range(0, 1));
            s.wa     = 4'($urandom_range(0, 15));
            s.result = $urandom;
            s.wdata  = $urandom;
            applyStimulus(s, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
